// File: rtl/pxs_court_gen.sv
// pxs_court_gen: draws the court (dashed middle line, top and bottom lines)
// over a VGA stream and flashes the line colour after a goal.
// Optional feature: define PXS_COURT_FLASH_EN to build the goal-flash FSM,
// its frame/toggle counters and busy_o. Without it, goal_i is ignored,
// busy_o is tied low and the lines are always COLOR_LINE.
module pxs_court_gen #(
    parameter int         WIDTH_SCREEN  = 640,
    parameter int         HEIGHT_SCREEN = 480,
    parameter int         LINE_W        = 6,
    parameter int         DASH_BIT      = 6,
    parameter logic [2:0] COLOR_LINE    = 3'b111,
    parameter logic [2:0] COLOR_BG      = 3'b000,
    parameter logic [2:0] COLOR_FLASH   = 3'b100,
    parameter int         FLASH_FRAMES  = 120,
    parameter int         TOGGLE_FRAMES = 8
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic [22:0] VGAStr_i,
    input  logic        goal_i,
    output logic [25:0] RGBStr_o,
    output logic        busy_o
);

    // 11-bit bounds so a 10-bit coordinate never wraps in a compare
    localparam logic [10:0] MID_LO = 11'(WIDTH_SCREEN / 2 - LINE_W / 2);
    localparam logic [10:0] MID_HI = 11'(WIDTH_SCREEN / 2 + LINE_W / 2);
    localparam logic [10:0] TOP_HI = 11'(LINE_W);
    localparam logic [10:0] BOT_LO = 11'(HEIGHT_SCREEN - LINE_W);
    localparam logic [10:0] BOT_HI = 11'(HEIGHT_SCREEN);
    localparam logic [9:0]  FF_LAST = 10'(FLASH_FRAMES - 1);
    localparam logic [7:0]  TG_LAST = 8'(TOGGLE_FRAMES - 1);

    logic        act;
    logic [10:0] xc, yc;
    logic        on_mid, on_top, on_bot;
    logic [2:0]  line_color;
    logic [2:0]  rgb_nx;

    assign act = VGAStr_i[0];
    assign yc  = {1'b0, VGAStr_i[12:3]};
    assign xc  = {1'b0, VGAStr_i[22:13]};

    assign on_mid = (xc >= MID_LO) && (xc < MID_HI) && VGAStr_i[3 + DASH_BIT];
    assign on_top = (yc < TOP_HI);
    assign on_bot = (yc >= BOT_LO) && (yc < BOT_HI);

`ifdef PXS_COURT_FLASH_EN
    typedef enum logic {IDLE, FLASH} state_t;

    state_t     state, state_nx;
    logic [9:0] frame_cnt, frame_nx;
    logic [7:0] tog_cnt, tog_nx;
    logic       phase, phase_nx;
    logic       vs_q;
    logic       frame_tick;

    // VS rising edge; vs_q clears on reset so a tick right after release needs VS=1
    assign frame_tick = VGAStr_i[1] & ~vs_q;

    // FSM, counters and VS history registers
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            frame_cnt <= '0;
            tog_cnt   <= '0;
            phase     <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_cnt <= frame_nx;
            tog_cnt   <= tog_nx;
            phase     <= phase_nx;
            vs_q      <= VGAStr_i[1];
        end
    end

    // next state: a goal (re)starts the flash and wins over a coincident tick
    always_comb begin
        state_nx = state;
        frame_nx = frame_cnt;
        tog_nx   = tog_cnt;
        phase_nx = phase;
        if (goal_i) begin
            state_nx = FLASH;
            frame_nx = '0;
            tog_nx   = '0;
            phase_nx = 1'b1;
        end else if (state == FLASH && frame_tick) begin
            if (frame_cnt == FF_LAST) begin
                state_nx = IDLE;
                frame_nx = '0;
                tog_nx   = '0;
                phase_nx = 1'b0;
            end else begin
                frame_nx = frame_cnt + 10'd1;
                if (tog_cnt == TG_LAST) begin
                    tog_nx   = '0;
                    phase_nx = ~phase;
                end else begin
                    tog_nx = tog_cnt + 8'd1;
                end
            end
        end
    end

    assign line_color = (state == FLASH && phase) ? COLOR_FLASH : COLOR_LINE;
    assign busy_o     = (state == FLASH);
`else
    logic unused_flash;

    assign unused_flash = ^{goal_i, COLOR_FLASH, FF_LAST, TG_LAST};
    assign line_color   = COLOR_LINE;
    assign busy_o       = 1'b0;
`endif

    // pixel colour before registering; blanking forces black
    always_comb begin
        rgb_nx = 3'b000;
        if (act)
            rgb_nx = (on_mid || on_top || on_bot) ? line_color : COLOR_BG;
    end

    // one-cycle output register: colour plus delayed copy of the stream
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) RGBStr_o <= '0;
        else       RGBStr_o <= {rgb_nx, VGAStr_i};
    end

endmodule

// File: tb/tb_pxs_court_gen.sv
module tb_pxs_court_gen;

    logic        px_clk = 1'b0;
    logic        reset = 1'b0;
    logic [22:0] VGAStr_i = '0;
    logic        goal_i = 1'b0;
    logic [25:0] RGBStr_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    pxs_court_gen #(.FLASH_FRAMES(4), .TOGGLE_FRAMES(2)) dut (
        .px_clk  (px_clk),
        .reset   (reset),
        .VGAStr_i(VGAStr_i),
        .goal_i  (goal_i),
        .RGBStr_o(RGBStr_o),
        .busy_o  (busy_o)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        logic       act;
        logic [9:0] xc;
        logic [9:0] yc;
        logic [2:0] rgb;
    } vec_t;

    vec_t vt[16];

`ifdef PXS_COURT_FLASH_EN
    localparam logic [2:0] FL = 3'b100;
    localparam logic       BZ = 1'b1;
`else
    localparam logic [2:0] FL = 3'b111;
    localparam logic       BZ = 1'b0;
`endif
    localparam logic [2:0] LN = 3'b111;

    function automatic logic [22:0] mk(input logic a, input logic vs, input logic hs,
                                       input logic [9:0] y, input logic [9:0] x);
        return {x, y, hs, vs, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // apply inputs at a falling edge, check the registered result one edge later
    task automatic step(input logic [22:0] v, input logic g, input logic [2:0] exp_rgb,
                        input string nm);
        VGAStr_i = v;
        goal_i   = g;
        @(negedge px_clk);
        goal_i = 1'b0;
        chk({nm, "_rgb"}, 32'(RGBStr_o[25:23]), 32'(exp_rgb));
    endtask

    // one frame: a line pixel, then a VS pulse (optionally with goal_i)
    task automatic frame(input logic [2:0] c, input logic b, input logic g, input string nm);
        step(mk(1'b1, 1'b0, 1'b0, 10'd5, 10'd100), 1'b0, c, nm);
        step(mk(1'b0, 1'b1, 1'b0, 10'd0, 10'd0), g, 3'b000, {nm, "_vs"});
        chk({nm, "_busy"}, 32'(busy_o), 32'(b));
    endtask

    logic [22:0] lp;
    logic [22:0] v;

    initial begin
        lp = mk(1'b1, 1'b0, 1'b0, 10'd5, 10'd100);

        vt[0]  = '{1'b1, 10'd320, 10'd64,  3'b111};
        vt[1]  = '{1'b1, 10'd320, 10'd32,  3'b000};
        vt[2]  = '{1'b1, 10'd100, 10'd5,   3'b111};
        vt[3]  = '{1'b1, 10'd100, 10'd477, 3'b111};
        vt[4]  = '{1'b1, 10'd100, 10'd6,   3'b000};
        vt[5]  = '{1'b1, 10'd100, 10'd473, 3'b000};
        vt[6]  = '{1'b0, 10'd320, 10'd64,  3'b000};
        vt[7]  = '{1'b0, 10'd100, 10'd0,   3'b000};
        vt[8]  = '{1'b1, 10'd316, 10'd64,  3'b000};
        vt[9]  = '{1'b1, 10'd317, 10'd64,  3'b111};
        vt[10] = '{1'b1, 10'd322, 10'd64,  3'b111};
        vt[11] = '{1'b1, 10'd323, 10'd64,  3'b000};
        vt[12] = '{1'b1, 10'd100, 10'd474, 3'b111};
        vt[13] = '{1'b1, 10'd100, 10'd479, 3'b111};
        vt[14] = '{1'b1, 10'd100, 10'd480, 3'b000};
        vt[15] = '{1'b1, 10'd1000, 10'd1000, 3'b000};

        // reset state, with a line pixel driven on the input
        VGAStr_i = lp;
        #1 reset = 1'b1;
        #1;
        chk("rst_rgbstr", 32'(RGBStr_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(negedge px_clk);
        chk("rst_hold_rgbstr", 32'(RGBStr_o), 32'd0);
        reset = 1'b0;

        // static drawing vectors, also checking the stream pass-through
        for (int i = 0; i < 16; i++) begin
            v = mk(vt[i].act, 1'b0, i[0], vt[i].yc, vt[i].xc);
            step(v, 1'b0, vt[i].rgb, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_pass", i), 32'(RGBStr_o[22:0]), 32'(v));
        end
        chk("idle_busy", 32'(busy_o), 32'd0);

        // goal flash: 4 frames, colour toggles every 2 frames
        step(lp, 1'b1, LN, "goal1");
        chk("goal1_busy", 32'(busy_o), 32'(BZ));
        frame(FL, BZ,   1'b0, "f1_0");
        frame(FL, BZ,   1'b0, "f1_1");
        frame(LN, BZ,   1'b0, "f1_2");
        frame(LN, 1'b0, 1'b0, "f1_3");
        step(lp, 1'b0, LN, "f1_after");

        // restart: goal coincident with the 4th tick keeps the flash going
        step(lp, 1'b1, LN, "goal2");
        frame(FL, BZ, 1'b0, "f2_0");
        frame(FL, BZ, 1'b0, "f2_1");
        frame(LN, BZ, 1'b0, "f2_2");
        frame(LN, BZ, 1'b1, "f2_3r");
        frame(FL, BZ,   1'b0, "f3_0");
        frame(FL, BZ,   1'b0, "f3_1");
        frame(LN, BZ,   1'b0, "f3_2");
        frame(LN, 1'b0, 1'b0, "f3_3");

        // asynchronous reset in the middle of a flash
        step(lp, 1'b1, LN, "goal3");
        frame(FL, BZ, 1'b0, "f4_0");
        step(lp, 1'b0, FL, "f4_px");
        #2 reset = 1'b1;
        #1;
        chk("arst_rgbstr", 32'(RGBStr_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        @(negedge px_clk);
        reset = 1'b0;
        step(lp, 1'b0, LN, "post_rst");
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        frame(LN, 1'b0, 1'b0, "post_rst_f");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
